// File: rtl/tm1638_key_events.sv
// Debounces the TM1638 key bus and queues press/release events behind a valid/ready handshake.
// Optional autorepeat is compiled in when TM1638_KEY_EVENT_REPEAT_EN is defined.
module tm1638_key_events #(
  parameter int clk_mhz     = 50,
  parameter int w_key       = 8,
  parameter int debounce_ms = 10,
  parameter int fifo_depth  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [w_key-1:0]         keys_raw,
  output logic [w_key-1:0]         key_state,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic                     ev_press,
  output logic [$clog2(w_key)-1:0] ev_key,
  output logic                     overflow
);
  localparam int presc_max = clk_mhz * 1000 - 1;
  localparam int presc_w   = $clog2(clk_mhz * 1000);
  localparam int kw        = $clog2(w_key);
  localparam int cw        = $clog2(debounce_ms + 1);
  localparam int aw        = $clog2(fifo_depth);

  logic [presc_w-1:0] presc;
  logic               tick;

  assign tick = (presc == presc_w'(presc_max));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  logic [w_key-1:0] stable;

  for (genvar gi = 0; gi < w_key; gi++) begin : g_deb
    logic [cw-1:0] cnt;
    logic          st;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
        st  <= 1'b0;
      end else if (keys_raw[gi] == st) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt == cw'(debounce_ms - 1)) begin
          cnt <= '0;
          st  <= ~st;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign stable[gi] = st;
  end

  assign key_state = stable;

  // A key is pending while its stable level differs from the last level we queued for it.
  logic [w_key-1:0] reported;
  logic [w_key-1:0] pending;
  logic             pend_any;
  logic [kw-1:0]    pend_idx;

  assign pending = stable ^ reported;

  always_comb begin
    pend_any = 1'b0;
    pend_idx = '0;
    for (int i = w_key - 1; i >= 0; i--) begin
      if (pending[i]) begin
        pend_any = 1'b1;
        pend_idx = kw'(i);
      end
    end
  end

  logic [kw:0]   mem [fifo_depth];
  logic [aw-1:0] wr_ptr;
  logic [aw-1:0] rd_ptr;
  logic [aw:0]   count;
  logic          full;
  logic          pop;
  logic          push_req;
  logic          push;
  logic [kw:0]   push_data;
  logic [kw:0]   head;

  assign full     = (count == (aw + 1)'(fifo_depth));
  assign ev_valid = (count != '0);
  assign pop      = ev_valid && ev_ready;
  assign push     = push_req && !full;

`ifdef TM1638_KEY_EVENT_REPEAT_EN
  logic [8:0]    rep_cnt;
  logic          rep_first;
  logic          rep_armed;
  logic          rep_fire;
  logic          held_any;
  logic [kw-1:0] held_idx;

  always_comb begin
    held_any = 1'b0;
    held_idx = '0;
    for (int i = w_key - 1; i >= 0; i--) begin
      if (stable[i]) begin
        held_any = 1'b1;
        held_idx = kw'(i);
      end
    end
  end

  // Any change in the held set shows up as a pending bit, which restarts the timer.
  assign rep_armed = held_any && !pend_any;
  assign rep_fire  = rep_armed && tick && (rep_cnt == (rep_first ? 9'd499 : 9'd99));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (!rep_armed) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (tick) begin
      if (rep_fire) begin
        rep_cnt   <= '0;
        rep_first <= 1'b0;
      end else begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end
  end
`endif

  always_comb begin
    push_req  = pend_any;
    push_data = {stable[pend_idx], pend_idx};
`ifdef TM1638_KEY_EVENT_REPEAT_EN
    if (!pend_any && rep_fire) begin
      push_req  = 1'b1;
      push_data = {1'b1, held_idx};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      reported <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pend_any && !full) reported[pend_idx] <= ~reported[pend_idx];
      if (push_req && full)  overflow <= 1'b1;
    end
  end

  // Gate the head so the outputs read zero whenever the queue is empty.
  assign head     = mem[rd_ptr];
  assign ev_press = ev_valid & head[kw];
  assign ev_key   = ev_valid ? head[kw-1:0] : '0;

endmodule

// File: tb/tb_tm1638_key_events.sv
// Scoreboard bench for tm1638_key_events: expected events are queued by the stimulus and
// checked by an independent monitor on each handshake.
module tb_tm1638_key_events;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] keys_raw = 8'h00;
  logic [7:0] key_state;
  logic       ev_valid;
  logic       ev_ready = 1'b0;
  logic       ev_press;
  logic [2:0] ev_key;
  logic       overflow;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int n0;
  logic [3:0] sb [$];
  int pop_cyc [$];
  logic [3:0] exp_ev;

  tm1638_key_events #(
    .clk_mhz(1), .w_key(8), .debounce_ms(2), .fifo_depth(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .keys_raw(keys_raw), .key_state(key_state),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_press(ev_press),
    .ev_key(ev_key), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: one line per accepted event, compared against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && ev_valid && ev_ready) begin
      pop_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_event: got press=%0d key=%0d, expected none", ev_press, ev_key);
      end else begin
        exp_ev = sb.pop_front();
        $display("event cycle=%0d press=%0d key=%0d (expected press=%0d key=%0d)",
                 cyc, ev_press, ev_key, exp_ev[3], exp_ev[2:0]);
        chk("event", {28'd0, ev_press, ev_key}, {28'd0, exp_ev});
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    step(3);
    chk("rst_key_state", key_state, 0);
    chk("rst_ev_valid", ev_valid, 0);
    chk("rst_ev_press", ev_press, 0);
    chk("rst_ev_key", ev_key, 0);
    chk("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    ev_ready = 1'b1;

    // Single press/release of key 2
    keys_raw = 8'h04; sb.push_back({1'b1, 3'd2});
    step(3000);
    chk("t1_press_state", key_state, 8'h04);
    keys_raw = 8'h00; sb.push_back({1'b0, 3'd2});
    step(3000);
    chk("t1_release_state", key_state, 8'h00);
    chk("t1_event_count", pop_cyc.size(), 2);

    // Bounce on key 5: never stable for two ticks
    for (int i = 0; i < 20; i++) begin
      keys_raw[5] = ~keys_raw[5];
      step(500);
    end
    step(3000);
    chk("bounce_state", key_state, 8'h00);
    chk("bounce_event_count", pop_cyc.size(), 2);

    // Simultaneous edges on keys 0, 4, 7
    n0 = pop_cyc.size();
    keys_raw = 8'h91;
    sb.push_back({1'b1, 3'd0}); sb.push_back({1'b1, 3'd4}); sb.push_back({1'b1, 3'd7});
    step(3000);
    chk("simul_state", key_state, 8'h91);
    chk("simul_event_count", pop_cyc.size(), n0 + 3);
    chk("simul_gap_1", pop_cyc[n0+1] - pop_cyc[n0], 1);
    chk("simul_gap_2", pop_cyc[n0+2] - pop_cyc[n0+1], 1);
    keys_raw = 8'h00;
    sb.push_back({1'b0, 3'd0}); sb.push_back({1'b0, 3'd4}); sb.push_back({1'b0, 3'd7});
    step(3000);
    chk("simul_release_count", pop_cyc.size(), n0 + 6);
    chk("pre_bp_overflow", overflow, 0);

    // Backpressure: press 0,1,2 then release 0,1,2 with the consumer stalled
    ev_ready = 1'b0;
    n0 = pop_cyc.size();
    keys_raw = 8'h01; sb.push_back({1'b1, 3'd0}); step(3000);
    chk("bp_head_1", {ev_press, ev_key}, {1'b1, 3'd0});
    keys_raw = 8'h03; sb.push_back({1'b1, 3'd1}); step(3000);
    chk("bp_head_2", {ev_press, ev_key}, {1'b1, 3'd0});
    keys_raw = 8'h07; sb.push_back({1'b1, 3'd2}); step(3000);
    chk("bp_head_3", {ev_press, ev_key}, {1'b1, 3'd0});
    keys_raw = 8'h06; sb.push_back({1'b0, 3'd0}); step(3000);
    chk("bp_full_no_overflow", overflow, 0);
    keys_raw = 8'h04; step(3000);
    chk("bp_overflow_set", overflow, 1);
    keys_raw = 8'h00; step(3000);
    chk("bp_head_4", {ev_press, ev_key}, {1'b1, 3'd0});
    chk("bp_valid", ev_valid, 1);
    chk("bp_no_pops_stalled", pop_cyc.size(), n0);
    sb.push_back({1'b0, 3'd1}); sb.push_back({1'b0, 3'd2});
    ev_ready = 1'b1;
    step(20);
    chk("bp_drain_count", pop_cyc.size(), n0 + 6);
    chk("bp_overflow_sticky", overflow, 1);
    chk("bp_empty", ev_valid, 0);

    // Async reset while an event is waiting and key 3 is held
    ev_ready = 1'b0;
    keys_raw = 8'h08;
    step(3000);
    chk("rst2_pre_valid", ev_valid, 1);
    chk("rst2_pre_head", {ev_press, ev_key}, {1'b1, 3'd3});
    #2 rst_n = 1'b0;
    #1;
    chk("rst2_key_state", key_state, 0);
    chk("rst2_ev_valid", ev_valid, 0);
    chk("rst2_ev_press", ev_press, 0);
    chk("rst2_ev_key", ev_key, 0);
    chk("rst2_overflow", overflow, 0);
    step(5);
    rst_n = 1'b1;
    ev_ready = 1'b1;
    n0 = pop_cyc.size();
    sb.push_back({1'b1, 3'd3});
    step(3000);
    chk("rst2_repress_state", key_state, 8'h08);
    chk("rst2_single_event", pop_cyc.size(), n0 + 1);
    keys_raw = 8'h00; sb.push_back({1'b0, 3'd3});
    step(3000);

    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
